truth_table_scanner: RTL and testbench

Self-checking stimulus/capture stage for the lab's 3-input combinational blocks. It drives a, b and c through all eight input combinations, from 000 to 111. For each vector it holds the inputs for a programmable dwell and samples the block's y output on the last cycle of that dwell. It assembles the eight samples into an 8-bit truth-table word, compares the word against an expected table and reports pass/fail, the mismatch count and the first failing vector.

---
 rtl/truth_table_scanner.sv | 116 +++++++++++
 tb/tb_truth_table_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus/capture stage for 3-input combinational blocks: walks {a,b,c}
// through 000..111, samples y at the end of each dwell and grades the captured table.
module truth_table_scanner #(
   parameter int unsigned DWELL = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] tbl,
   output logic [3:0] err_cnt,
   output logic [2:0] first_fail,
   output logic [1:0] state_dbg
);

   // Handshake: start is a level request taken only on an edge where the FSM is in
   // IDLE (including the done cycle); while busy=1 it is ignored. done is a one-cycle
   // pulse and the result outputs hold until the next accepted start.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [7:0] LAST = 8'(DWELL - 1);

   state_t     state;
   logic [2:0] idx;
   logic [7:0] cnt;
   logic [7:0] exp_q;
   logic [7:0] diff;
   logic [3:0] pop;
   logic [2:0] low;

   assign state_dbg = state;

   // Scanning downward leaves the lowest mismatching index in low.
   always_comb begin
      diff = tbl ^ exp_q;
      pop  = 4'd0;
      low  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         pop = pop + 4'(diff[i]);
         if (diff[i]) low = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= 3'd0;
         cnt        <= 8'd0;
         exp_q      <= 8'd0;
         a          <= 1'b0;
         b          <= 1'b0;
         c          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         tbl        <= 8'd0;
         err_cnt    <= 4'd0;
         first_fail <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               {a, b, c} <= 3'b000;
               if (start) begin
                  exp_q      <= expected;
                  tbl        <= 8'd0;
                  pass       <= 1'b0;
                  err_cnt    <= 4'd0;
                  first_fail <= 3'd0;
                  idx        <= 3'd0;
                  cnt        <= 8'd0;
                  busy       <= 1'b1;
                  state      <= APPLY;
               end
            end
            APPLY: begin
               if (cnt < LAST) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  // Sample edge: capture y and present the next vector on the same edge.
                  tbl[idx] <= y;
                  cnt      <= 8'd0;
                  if (idx != 3'd7) begin
                     idx       <= idx + 3'd1;
                     {a, b, c} <= idx + 3'd1;
                  end else begin
                     {a, b, c} <= 3'b000;
                     state     <= CHECK;
                  end
               end
            end
            CHECK: begin
               pass       <= (diff == 8'd0);
               err_cnt    <= pop;
               first_fail <= low;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench for truth_table_scanner against a per-vector
// reference model of the captured table and its grading.
module tb_truth_table_scanner;

   localparam int D5 = 5;
   localparam int D4 = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start5, start4;
   logic [7:0] expected5, expected4;
   logic       y5, y4;
   logic       a5, b5, c5, busy5, done5, pass5;
   logic       a4, b4, c4, busy4, done4, pass4;
   logic [7:0] tbl5, tbl4;
   logic [3:0] err5, err4;
   logic [2:0] ff5, ff4;
   logic [1:0] st5, st4;

   int         n_checks = 0;
   int         n_errors = 0;
   int         mode;
   logic [7:0] rnd_fn;

   always #5 clk = ~clk;

   truth_table_scanner #(.DWELL(D5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start5), .expected(expected5), .y(y5),
      .a(a5), .b(b5), .c(c5), .busy(busy5), .done(done5), .pass(pass5),
      .tbl(tbl5), .err_cnt(err5), .first_fail(ff5), .state_dbg(st5));

   truth_table_scanner #(.DWELL(D4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .expected(expected4), .y(y4),
      .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
      .tbl(tbl4), .err_cnt(err4), .first_fail(ff4), .state_dbg(st4));

   // Block-under-test models: 0 majority, 1 stuck-0, 2 stuck-1, else random table.
   function automatic logic y_model(input int m, input logic [7:0] fn, input logic [2:0] v);
      case (m)
         0:       return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
         1:       return 1'b0;
         2:       return 1'b1;
         default: return fn[v];
      endcase
   endfunction

   always_comb y5 = y_model(mode, rnd_fn, {a5, b5, c5});

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full scan on the DWELL=5 instance with per-cycle checks of the stimulus
   // sequence, busy/done timing and the graded result.
   task automatic run_scan(input logic [7:0] exp_tbl, input bit hold);
      logic [7:0] t;
      logic [7:0] d;
      int         nerr;
      int         first;
      t = 8'd0;
      for (int v = 0; v < 8; v++) t[v] = y_model(mode, rnd_fn, 3'(v));
      d     = t ^ exp_tbl;
      nerr  = $countones(d);
      first = 0;
      for (int v = 0; v < 8; v++) if (d[v]) begin first = v; break; end

      @(negedge clk);
      start5    = 1'b1;
      expected5 = exp_tbl;
      @(posedge clk);
      #1;
      if (!hold) start5 = 1'b0;
      expected5 = 8'($urandom);
      check_eq("accept_busy_done", {30'd0, busy5, done5}, 32'b10);
      check_eq("accept_abc", {29'd0, a5, b5, c5}, 32'd0);
      for (int n = 1; n <= 8 * D5 + 1; n++) begin
         @(posedge clk);
         #1;
         if (n % 7 == 3) expected5 = 8'($urandom);
         if (n <= 8 * D5) begin
            check_eq("abc_seq", {29'd0, a5, b5, c5}, (n < 8 * D5) ? n / D5 : 0);
            check_eq("busy_done_scan", {30'd0, busy5, done5}, 32'b10);
         end else begin
            check_eq("busy_done_end", {30'd0, busy5, done5}, 32'b01);
         end
      end
      check_eq("table", {24'd0, tbl5}, {24'd0, t});
      check_eq("pass", {31'd0, pass5}, {31'd0, (d == 8'd0)});
      check_eq("err_cnt", {28'd0, err5}, nerr);
      check_eq("first_fail", {29'd0, ff5}, first);
      if (!hold) begin
         @(posedge clk);
         #1;
         check_eq("held_after_done", {busy5, done5, pass5, tbl5, err5, ff5},
                  {2'b00, (d == 8'd0), t, 4'(nerr), 3'(first)});
      end
   endtask

   initial begin
      int  saw_done;
      rst = 1'b1; start5 = 1'b0; start4 = 1'b0;
      expected5 = 8'd0; expected4 = 8'd0; y4 = 1'b0;
      mode = 0; rnd_fn = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset5", {a5, b5, c5, busy5, done5, pass5, tbl5, err5, ff5, st5}, 0);
      check_eq("reset4", {a4, b4, c4, busy4, done4, pass4, tbl4, err4, ff4, st4}, 0);
      rst = 1'b0;

      mode = 0; run_scan(8'hE8, 1'b0);
      mode = 0; run_scan(8'h96, 1'b0);
      check_eq("xor_vs_maj_err", {28'd0, err5}, 6);
      check_eq("xor_vs_maj_ff", {29'd0, ff5}, 1);
      mode = 1; run_scan(8'h00, 1'b0);
      mode = 2; run_scan(8'hFF, 1'b0);
      mode = 2; run_scan(8'h00, 1'b0);
      check_eq("stuck1_err8", {28'd0, err5}, 8);

      for (int r = 0; r < 4; r++) begin
         mode   = 3;
         rnd_fn = 8'($urandom);
         run_scan((r == 1) ? rnd_fn : 8'($urandom), 1'b0);
      end

      // start held high: ignored mid-scan, re-accepted on the done cycle.
      mode = 3; rnd_fn = 8'($urandom);
      run_scan(8'($urandom), 1'b1);
      run_scan(8'($urandom), 1'b0);

      // Reset mid-scan aborts without a done pulse.
      mode = 0;
      @(negedge clk);
      start5 = 1'b1; expected5 = 8'hE8;
      @(posedge clk);
      #1;
      start5 = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("abort_reset", {a5, b5, c5, busy5, done5, pass5, tbl5, err5, ff5, st5}, 0);
      saw_done = 0;
      for (int n = 0; n < 45; n++) begin
         @(posedge clk);
         #1;
         if (done5 || busy5) saw_done = 1;
      end
      check_eq("abort_no_done", saw_done, 0);
      run_scan(8'hE8, 1'b0);

      // DWELL=4 instance: y correct only on sample edges, inverted otherwise.
      @(negedge clk);
      start4 = 1'b1; expected4 = 8'hE8;
      y4 = ~y_model(0, 8'd0, {a4, b4, c4});
      @(posedge clk);
      #1;
      start4 = 1'b0;
      for (int n = 1; n <= 8 * D4 + 1; n++) begin
         @(negedge clk);
         y4 = (n % D4 == 0) ? y_model(0, 8'd0, {a4, b4, c4}) : ~y_model(0, 8'd0, {a4, b4, c4});
         @(posedge clk);
         #1;
         if (n == 8 * D4) check_eq("d4_not_done_yet", {31'd0, done4}, 0);
      end
      check_eq("d4_done", {30'd0, busy4, done4}, 32'b01);
      check_eq("d4_table", {24'd0, tbl4}, 32'hE8);
      check_eq("d4_pass", {31'd0, pass4}, 1);
      check_eq("d4_err", {28'd0, err4}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
